// File: rtl/fp_sub_result_buffer_pkg.sv
// Shared types and default parameters for the FPSub32 issue/collect buffer.
package fp_sub_pkg;

   localparam int FP_SUB_LATENCY = 14;
   localparam int FP_SUB_DEPTH   = 16;
   localparam int FP_SUB_TAG_W   = 4;

   typedef logic [31:0] fp32_t;

   typedef struct packed {
      fp32_t                    data;
      logic [FP_SUB_TAG_W-1:0]  tag;
   } fp_sub_resp_t;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fp_sub_result_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; used for both the tag and the result queues.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_sub_result_buffer.sv
// Issue/collect wrapper for the fixed-latency FPSub32: credit-gated issue, tag reattachment, drain.
// Optional protocol checking is enabled with FP_SUB_BUF_CHECK_EN.
module fp_sub_result_buffer
   import fp_sub_pkg::*;
#(
   parameter int LATENCY = FP_SUB_LATENCY,
   parameter int DEPTH   = FP_SUB_DEPTH,
   parameter int TAG_W   = FP_SUB_TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             unit_go,
   output logic [31:0]      unit_a,
   output logic [31:0]      unit_b,
   input  logic             unit_done,
   input  logic [31:0]      unit_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             err_sticky
);

   localparam int CNT_W   = occ_width(DEPTH);
   localparam int DRAIN_W = $clog2(LATENCY + 1);
   localparam int RESP_W  = $bits(fp_sub_resp_t);

   logic [DRAIN_W-1:0] drain_cnt;
   logic               draining;
   logic [CNT_W-1:0]   tag_count;
   logic [CNT_W-1:0]   res_count;
   logic [CNT_W:0]     credit_used;
   logic               tag_empty;
   logic               res_empty;
   logic [TAG_W-1:0]   tag_head;
   logic               collect;
   logic               res_pop;
   fp_sub_resp_t       res_in;
   fp_sub_resp_t       res_out;

   // The unit ignores reset, so anything it emits for LATENCY cycles after reset is stale.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drain_cnt <= DRAIN_W'(LATENCY);
      end else if (draining) begin
         drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
   end

   assign draining    = (drain_cnt != '0);
   assign credit_used = {1'b0, tag_count} + {1'b0, res_count};
   assign req_ready   = !draining && (credit_used < (CNT_W + 1)'(DEPTH));

   assign unit_go = req_valid && req_ready;
   assign unit_a  = req_a;
   assign unit_b  = req_b;

   assign collect    = unit_done && !draining && !tag_empty;
   assign res_pop    = resp_valid && resp_ready;
   assign res_in     = '{data: unit_result, tag: tag_head};
   assign resp_valid = !res_empty;
   assign resp_data  = res_out.data;
   assign resp_tag   = res_out.tag;

   sync_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (unit_go),
      .push_data (req_tag),
      .pop       (collect),
      .pop_data  (tag_head),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   sync_fifo #(
      .WIDTH (RESP_W),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (collect),
      .push_data (res_in),
      .pop       (res_pop),
      .pop_data  (res_out),
      .empty     (res_empty),
      .count     (res_count)
   );

`ifdef FP_SUB_BUF_CHECK_EN
   logic err_event;
   logic err_q;

   always_comb begin
      err_event = (unit_done && !draining && tag_empty)
               || (unit_go && tag_count == CNT_W'(DEPTH))
               || (collect && res_count == CNT_W'(DEPTH) && !res_pop);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (err_event) begin
         err_q <= 1'b1;
         $error("fp_sub_result_buffer: unexpected unit_done or push into a full FIFO");
      end
   end

   assign err_sticky = err_q;
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_sub_result_buffer.sv
// Scoreboard bench for fp_sub_result_buffer with a behavioural FPSub32 that ignores reset.
module tb_fp_sub_result_buffer;
   import fp_sub_pkg::*;

   localparam int LAT   = 14;
   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [31:0]      req_a = '0;
   logic [31:0]      req_b = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             unit_go;
   logic [31:0]      unit_a;
   logic [31:0]      unit_b;
   logic             unit_done;
   logic [31:0]      unit_result;
   logic             resp_valid;
   logic             resp_ready = 1'b1;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             err_sticky;

   logic             force_done = 1'b0;
   logic             toggle_en = 1'b0;
   logic             pv [LAT] = '{default: 1'b0};
   fp32_t            pa [LAT] = '{default: '0};
   fp32_t            pb [LAT] = '{default: '0};

   int               tests_run = 0;
   int               tests_failed = 0;
   int               cur_ia = 0;
   int               cur_ib = 0;
   logic [TAG_W-1:0] tag_ctr = '0;
   int               accepted_total = 0;
   int               popped_total = 0;
   int               max_out = 0;
   bit               triple_seen = 1'b0;
   fp_sub_resp_t     exp_q [$];
   logic             hold_prev = 1'b0;
   logic [36:0]      resp_prev = '0;

`ifdef FP_SUB_BUF_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clock = ~clock;

   fp_sub_result_buffer dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_tag     (req_tag),
      .unit_go     (unit_go),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .unit_done   (unit_done),
      .unit_result (unit_result),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_tag    (resp_tag),
      .err_sticky  (err_sticky)
   );

   // Exact IEEE-754 single encoding of a small integer.
   function automatic fp32_t to_fp(input int v);
      int    m;
      int    p;
      fp32_t r;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++) begin
         if (m[i]) p = i;
      end
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'(m << (23 - p));
      return r;
   endfunction

   function automatic int from_fp(input fp32_t f);
      int e;
      int mag;
      if (f[30:23] == 8'd0) return 0;
      e   = int'(f[30:23]) - 127;
      mag = int'({1'b1, f[22:0]}) >> (23 - e);
      return f[31] ? -mag : mag;
   endfunction

   // FPSub32 stand-in: fixed latency, no stall, no reset.
   always @(posedge clock) begin
      pv[0] <= unit_go;
      pa[0] <= unit_a;
      pb[0] <= unit_b;
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end

   assign unit_done   = pv[LAT-1] | force_done;
   assign unit_result = to_fp(from_fp(pa[LAT-1]) - from_fp(pb[LAT-1]));

   always @(posedge clock) begin
      #1;
      if (toggle_en) resp_ready = ~resp_ready;
   end

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every accepted request queues its reference result in issue order.
   always @(negedge clock) begin
      if (reset && req_valid && req_ready) begin
         exp_q.push_back('{data: to_fp(cur_ia - cur_ib), tag: req_tag});
         accepted_total++;
         if (accepted_total - popped_total > max_out) max_out = accepted_total - popped_total;
         if (unit_done && resp_valid && resp_ready) triple_seen = 1'b1;
      end
   end

   always @(negedge clock) begin
      if (reset && hold_prev) begin
         check_output("resp_stable", {resp_valid, resp_data, resp_tag}, {1'b1, resp_prev[35:0]});
      end
      if (reset && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            check_output("resp_unexpected", 64'd1, 64'd0);
         end else begin
            fp_sub_resp_t e;
            e = exp_q.pop_front();
            check_output("resp_data", resp_data, e.data);
            check_output("resp_tag", resp_tag, e.tag);
            popped_total++;
         end
      end
      hold_prev = reset && resp_valid && !resp_ready;
      resp_prev = {1'b1, resp_data, resp_tag};
   end

   // Offers random requests starting just after a posedge; returns how many were accepted.
   task automatic apply_stimulus(input int n, input int budget, input bit go_every, output int accepted);
      bit need_new;
      accepted = 0;
      need_new = 1'b1;
      for (int c = 0; c < budget && accepted < n; c++) begin
         if (need_new) begin
            cur_ia    = int'($urandom_range(2000)) - 1000;
            cur_ib    = int'($urandom_range(2000)) - 1000;
            req_a     = to_fp(cur_ia);
            req_b     = to_fp(cur_ib);
            req_tag   = tag_ctr;
            req_valid = 1'b1;
            need_new  = 1'b0;
         end
         @(negedge clock);
         if (go_every) check_output("go_every_cycle", unit_go, 1);
         if (req_valid && req_ready) begin
            accepted++;
            tag_ctr++;
            need_new = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         @(posedge clock);
      end
      @(posedge clock);
      #1;
      check_output("drain_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      int lat;
      int bad;

      // Reset state with a request already pending.
      #2;
      reset     = 1'b0;
      cur_ia    = 3;
      cur_ib    = 1;
      req_a     = to_fp(3);
      req_b     = to_fp(1);
      req_tag   = 4'd5;
      req_valid = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_output("reset_req_ready", req_ready, 0);
      check_output("reset_resp_valid", resp_valid, 0);
      check_output("reset_unit_go", unit_go, 0);
      check_output("reset_err_sticky", err_sticky, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Drain window, then the first go and its response.
      for (int i = 0; i < LAT; i++) begin
         @(negedge clock);
         check_output("drain_ready_go", {req_ready, unit_go}, 0);
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      check_output("first_go", {req_ready, unit_go}, 2'b11);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      lat = 31;
      for (int k = 1; k <= 30; k++) begin
         if (resp_valid) begin
            lat = k;
            break;
         end
         @(posedge clock);
         #1;
      end
      check_output("first_resp_latency", lat, LAT + 1);
      check_output("first_resp_value", {resp_data, resp_tag}, {32'h4000_0000, 4'd5});
      wait_drain(100);

      // Streaming at full rate.
      tag_ctr    = '0;
      resp_ready = 1'b1;
      apply_stimulus(32, 40, 1'b1, acc);
      check_output("stream_accepted", acc, 32);
      wait_drain(100);

      // Credit limit with downstream stalled.
      resp_ready = 1'b0;
      apply_stimulus(20, 40, 1'b0, acc);
      check_output("stalled_accepted", acc, DEPTH);
      @(negedge clock);
      check_output("stalled_req_ready", req_ready, 0);
      @(posedge clock);
      #1;
      resp_ready = 1'b1;
      apply_stimulus(4, 200, 1'b0, acc);
      check_output("remaining_accepted", acc, 4);
      wait_drain(100);

      // Toggling resp_ready, once in each phase.
      max_out     = 0;
      triple_seen = 1'b0;
      toggle_en   = 1'b1;
      @(posedge clock);
      #2;
      if (resp_ready) begin
         @(posedge clock);
         #2;
      end
      apply_stimulus(30, 300, 1'b0, acc);
      check_output("toggle_a_accepted", acc, 30);
      wait_drain(300);
      @(posedge clock);
      #2;
      if (!resp_ready) begin
         @(posedge clock);
         #2;
      end
      apply_stimulus(30, 300, 1'b0, acc);
      check_output("toggle_b_accepted", acc, 30);
      wait_drain(300);
      toggle_en = 1'b0;
      #5;
      resp_ready = 1'b1;
      check_output("max_outstanding_le_depth", max_out <= DEPTH, 1);
      check_output("issue_done_pop_same_cycle", triple_seen, 1);

      // Reset with ops in flight; their dones must be swallowed by the drain.
      @(posedge clock);
      #1;
      apply_stimulus(10, 20, 1'b0, acc);
      check_output("inflight_accepted", acc, 10);
      reset = 1'b0;
      exp_q.delete();
      accepted_total = 0;
      popped_total   = 0;
      @(negedge clock);
      check_output("midreset_resp_valid", resp_valid, 0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (resp_valid || err_sticky || (i < LAT && req_ready)) bad++;
      end
      check_output("stale_done_cycles", bad, 0);
      @(posedge clock);
      #1;
      apply_stimulus(5, 40, 1'b0, acc);
      check_output("post_reset_accepted", acc, 5);
      wait_drain(100);

      // Spurious done with nothing in flight.
      repeat (20) @(posedge clock);
      #1;
      force_done = 1'b1;
      @(posedge clock);
      #1;
      force_done = 1'b0;
      check_output("spurious_err_sticky", err_sticky, EXP_ERR);
      check_output("spurious_resp_valid", resp_valid, 0);
      repeat (3) @(posedge clock);
      #1;
      check_output("spurious_hold", {err_sticky, resp_valid}, {EXP_ERR, 1'b0});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
